activation_control: RTL and testbench

- Sequencer for the activation stage of the VEGETA TPU datapath.
- Accepts one activation instruction: accumulator base address, unified-buffer base address, row count, activation function and signedness.
- Issues one accumulator row read per cycle, feeding the activation unit. It also tracks the fixed pipeline latency so it can emit the matching unified-buffer write strobe and address for each activated row.
- Sits between the instruction issue logic and the accumulator / activation / unified-buffer trio.

---
 rtl/activation_control_if.sv | 28 ++
 rtl/activation_control.sv | 128 ++++++++++++
 tb/tb_activation_control.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/activation_control_if.sv
// Instruction handshake between the issue logic and the activation sequencer.
// The issue side holds an instruction on these signals until busy is low.
interface activation_control_if #(
  parameter int unsigned ACC_ADDR_WIDTH    = 9,
  parameter int unsigned BUFFER_ADDR_WIDTH = 24,
  parameter int unsigned LENGTH_WIDTH      = 32,
  parameter int unsigned ACT_WIDTH         = 4
);
  logic                         instr_valid;
  logic [ACC_ADDR_WIDTH-1:0]    instr_acc_addr;
  logic [BUFFER_ADDR_WIDTH-1:0] instr_buf_addr;
  logic [LENGTH_WIDTH-1:0]      instr_length;
  logic [ACT_WIDTH-1:0]         instr_activation;
  logic                         instr_signed;
  logic                         busy;

  modport master (
    output instr_valid, instr_acc_addr, instr_buf_addr, instr_length,
           instr_activation, instr_signed,
    input  busy
  );

  modport slave (
    input  instr_valid, instr_acc_addr, instr_buf_addr, instr_length,
           instr_activation, instr_signed,
    output busy
  );
endinterface

// File: rtl/activation_control.sv
// Activation-stage sequencer: streams accumulator row reads and emits the
// matching unified-buffer writes after a fixed activation pipeline latency.
module activation_control #(
  parameter int unsigned MATRIX_WIDTH      = 14,
  parameter int unsigned ACC_ADDR_WIDTH    = 9,
  parameter int unsigned BUFFER_ADDR_WIDTH = 24,
  parameter int unsigned LENGTH_WIDTH      = 32,
  parameter int unsigned PIPE_LATENCY      = 4,
  parameter int unsigned ACT_WIDTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  activation_control_if.slave          instr,
  output logic                         resource_busy,
  output logic                         acc_read_enable,
  output logic [ACC_ADDR_WIDTH-1:0]    acc_read_address,
  output logic [ACT_WIDTH-1:0]         activation_function,
  output logic                         signed_not_unsigned,
  output logic                         buffer_write_enable,
  output logic [BUFFER_ADDR_WIDTH-1:0] buffer_write_address
);

  if (PIPE_LATENCY < 1 || PIPE_LATENCY > 8 || MATRIX_WIDTH == 0) begin : g_bad_params
    $error("activation_control: PIPE_LATENCY must be 1..8 and MATRIX_WIDTH nonzero");
  end

  // Bits of the valid pipe that are still inside it after one more shift.
  localparam logic [PIPE_LATENCY-1:0] SHIFT_MASK = {PIPE_LATENCY{1'b1}} >> 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                       state;
  logic [LENGTH_WIDTH-1:0]      rows_left;
  logic                         rd_q;
  logic [ACC_ADDR_WIDTH-1:0]    rd_addr_q;
  logic [BUFFER_ADDR_WIDTH-1:0] buf_addr_q;
  logic                         busy_q;
  logic                         res_busy_q;
  logic [ACT_WIDTH-1:0]         act_q;
  logic                         sgn_q;
  logic [PIPE_LATENCY-1:0]      pipe_v;
  logic [BUFFER_ADDR_WIDTH-1:0] pipe_a [PIPE_LATENCY];
  logic                         drained_c;

  // Nothing valid will remain in the pipe after the next shift.
  assign drained_c = ((pipe_v & SHIFT_MASK) == '0) && !rd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rows_left  <= '0;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      buf_addr_q <= '0;
      busy_q     <= 1'b0;
      res_busy_q <= 1'b0;
      act_q      <= '0;
      sgn_q      <= 1'b0;
      pipe_v     <= '0;
      for (int i = 0; i < int'(PIPE_LATENCY); i++) begin
        pipe_a[i] <= '0;
      end
    end else if (enable) begin
      // Latency pipe: the row read this cycle becomes a write PIPE_LATENCY cycles later.
      for (int i = int'(PIPE_LATENCY) - 1; i > 0; i--) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
      pipe_v[0] <= rd_q;
      pipe_a[0] <= buf_addr_q;

      case (state)
        IDLE: begin
          if (instr.instr_valid && (instr.instr_length != '0)) begin
            state      <= READ;
            rows_left  <= instr.instr_length - LENGTH_WIDTH'(1);
            rd_q       <= 1'b1;
            rd_addr_q  <= instr.instr_acc_addr;
            buf_addr_q <= instr.instr_buf_addr;
            busy_q     <= 1'b1;
            res_busy_q <= 1'b1;
            act_q      <= instr.instr_activation;
            sgn_q      <= instr.instr_signed;
          end
        end
        READ: begin
          if (rows_left == '0) begin
            state      <= DRAIN;
            rd_q       <= 1'b0;
            res_busy_q <= 1'b0;
          end else begin
            rows_left  <= rows_left - LENGTH_WIDTH'(1);
            rd_addr_q  <= rd_addr_q + ACC_ADDR_WIDTH'(1);
            buf_addr_q <= buf_addr_q + BUFFER_ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drained_c) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          rd_q       <= 1'b0;
          busy_q     <= 1'b0;
          res_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are suppressed while stalled so a frozen row is never counted twice.
  assign acc_read_enable      = rd_q & enable;
  assign acc_read_address     = rd_addr_q;
  assign buffer_write_enable  = pipe_v[PIPE_LATENCY-1] & enable;
  assign buffer_write_address = pipe_a[PIPE_LATENCY-1];
  assign resource_busy        = res_busy_q;
  assign activation_function  = act_q;
  assign signed_not_unsigned  = sgn_q;
  assign instr.busy           = busy_q;

endmodule

// File: tb/tb_activation_control.sv
// Randomized and directed bench for activation_control, checked every cycle
// against an effective-cycle-count model of the instruction timeline.
module tb_activation_control;
  localparam int unsigned AW = 9;
  localparam int unsigned BW = 24;
  localparam int unsigned LW = 32;
  localparam int unsigned P  = 4;
  localparam logic [3:0] NO_ACT  = 4'b0000;
  localparam logic [3:0] RELU    = 4'b0001;
  localparam logic [3:0] SIGMOID = 4'b1001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic resource_busy, acc_read_enable, signed_not_unsigned, buffer_write_enable;
  logic [AW-1:0] acc_read_address;
  logic [3:0]    activation_function;
  logic [BW-1:0] buffer_write_address;

  activation_control_if #(.ACC_ADDR_WIDTH(AW), .BUFFER_ADDR_WIDTH(BW),
                          .LENGTH_WIDTH(LW), .ACT_WIDTH(4)) bus ();

  activation_control #(.MATRIX_WIDTH(14), .ACC_ADDR_WIDTH(AW), .BUFFER_ADDR_WIDTH(BW),
                       .LENGTH_WIDTH(LW), .PIPE_LATENCY(P), .ACT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .instr(bus),
    .resource_busy(resource_busy), .acc_read_enable(acc_read_enable),
    .acc_read_address(acc_read_address), .activation_function(activation_function),
    .signed_not_unsigned(signed_not_unsigned), .buffer_write_enable(buffer_write_enable),
    .buffer_write_address(buffer_write_address)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  bit rand_en = 1'b0;

  // Model: an accepted instruction is a timeline indexed by enabled edges since accept.
  bit         m_active = 1'b0;
  longint     m_n = 0, m_e = 0, m_len = 0, m_acc = 0, m_buf = 0;
  logic [3:0] m_act = 4'b0000;
  logic       m_sgn = 1'b0;
  int         m_consumed = 0;

  function automatic bit m_busy();
    return m_active && ((m_n - m_e) < m_len + longint'(P));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_act    = NO_ACT;
      m_sgn    = 1'b0;
      m_n      = 0;
    end else if (enable) begin
      if (bus.instr_valid && !m_busy()) begin
        m_consumed++;
        if (bus.instr_length != 0) begin
          m_active = 1'b1;
          m_acc    = longint'(bus.instr_acc_addr);
          m_buf    = longint'(bus.instr_buf_addr);
          m_len    = longint'(bus.instr_length);
          m_act    = bus.instr_activation;
          m_sgn    = bus.instr_signed;
          m_e      = m_n + 1;
        end
      end
      m_n++;
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    longint d;
    bit e_res, e_rd, e_wr;
    if (chk_on) begin
      d     = m_n - m_e;
      e_res = m_active && d < m_len;
      e_rd  = e_res && enable;
      e_wr  = m_active && d >= longint'(P) && d < m_len + longint'(P) && enable;
      chk("busy", longint'(bus.busy), longint'(m_busy()));
      chk("resource_busy", longint'(resource_busy), longint'(e_res));
      chk("acc_read_enable", longint'(acc_read_enable), longint'(e_rd));
      if (e_rd) chk("acc_read_address", longint'(acc_read_address), (m_acc + d) % 512);
      chk("buffer_write_enable", longint'(buffer_write_enable), longint'(e_wr));
      if (e_wr) chk("buffer_write_address", longint'(buffer_write_address),
                    (m_buf + d - longint'(P)) % 64'h100_0000);
      chk("activation_function", longint'(activation_function), longint'(m_act));
      chk("signed_not_unsigned", longint'(signed_not_unsigned), longint'(m_sgn));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) enable = ($urandom_range(0, 9) != 0);
  endtask

  // Hold the instruction until the model consumes it (accept or zero-length drop).
  task automatic issue(input logic [AW-1:0] a, input logic [BW-1:0] b, input int len,
                       input logic [3:0] f, input logic s);
    int start = m_consumed;
    int budget = 0;
    bus.instr_acc_addr   = a;
    bus.instr_buf_addr   = b;
    bus.instr_length     = LW'(len);
    bus.instr_activation = f;
    bus.instr_signed     = s;
    bus.instr_valid      = 1'b1;
    while (m_consumed == start && budget < 400) begin
      step();
      budget++;
    end
    if (m_consumed == start) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: got no accept after %0d cycles, expected accept", budget);
    end
    bus.instr_valid = 1'b0;
  endtask

  task automatic expect_cycle(input string tag, input bit rd, input longint ra, input bit wr,
                              input longint wa, input bit bsy, input bit res);
    @(negedge clk);
    chk({tag, "_rd"}, longint'(acc_read_enable), longint'(rd));
    if (rd) chk({tag, "_rd_addr"}, longint'(acc_read_address), ra);
    chk({tag, "_wr"}, longint'(buffer_write_enable), longint'(wr));
    if (wr) chk({tag, "_wr_addr"}, longint'(buffer_write_address), wa);
    chk({tag, "_busy"}, longint'(bus.busy), longint'(bsy));
    chk({tag, "_res"}, longint'(resource_busy), longint'(res));
  endtask

  task automatic basic_run(input string tag);
    issue(9'd5, 24'd100, 3, RELU, 1'b1);
    expect_cycle(tag, 1, 5, 0, 0, 1, 1);
    expect_cycle(tag, 1, 6, 0, 0, 1, 1);
    expect_cycle(tag, 1, 7, 0, 0, 1, 1);
    expect_cycle(tag, 0, 0, 0, 0, 1, 0);
    expect_cycle(tag, 0, 0, 1, 100, 1, 0);
    expect_cycle(tag, 0, 0, 1, 101, 1, 0);
    expect_cycle(tag, 0, 0, 1, 102, 1, 0);
    expect_cycle(tag, 0, 0, 0, 0, 0, 0);
    chk({tag, "_act_hold"}, longint'(activation_function), longint'(RELU));
    chk({tag, "_sgn_hold"}, longint'(signed_not_unsigned), 1);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_acc_addr = '0;
    bus.instr_buf_addr = '0;
    bus.instr_length = '0;
    bus.instr_activation = NO_ACT;
    bus.instr_signed = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk_on = 1'b1;
    expect_cycle("reset", 0, 0, 0, 0, 0, 0);
    chk("reset_act", longint'(activation_function), longint'(NO_ACT));

    basic_run("basic");

    // Single row, then a zero-length instruction that must be dropped.
    issue(9'd33, 24'd77, 1, SIGMOID, 1'b0);
    expect_cycle("single", 1, 33, 0, 0, 1, 1);
    expect_cycle("single", 0, 0, 0, 0, 1, 0);
    expect_cycle("single", 0, 0, 0, 0, 1, 0);
    expect_cycle("single", 0, 0, 0, 0, 1, 0);
    expect_cycle("single", 0, 0, 1, 77, 1, 0);
    expect_cycle("single", 0, 0, 0, 0, 0, 0);
    issue(9'd7, 24'd7, 0, RELU, 1'b1);
    expect_cycle("zero_len", 0, 0, 0, 0, 0, 0);
    expect_cycle("zero_len", 0, 0, 0, 0, 0, 0);
    chk("zero_len_act", longint'(activation_function), longint'(SIGMOID));

    // Back-to-back: second instruction is presented while busy and held.
    issue(9'd100, 24'd1000, 5, RELU, 1'b0);
    issue(9'd200, 24'd2000, 2, SIGMOID, 1'b1);
    repeat (10) step();

    // Stall for two cycles after the second read.
    issue(9'd40, 24'd500, 4, SIGMOID, 1'b0);
    step();
    step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    expect_cycle("stall", 1, 42, 0, 0, 1, 1);
    expect_cycle("stall", 1, 43, 0, 0, 1, 1);
    expect_cycle("stall", 0, 0, 1, 500, 1, 0);
    expect_cycle("stall", 0, 0, 1, 501, 1, 0);
    expect_cycle("stall", 0, 0, 1, 502, 1, 0);
    expect_cycle("stall", 0, 0, 1, 503, 1, 0);
    expect_cycle("stall", 0, 0, 0, 0, 0, 0);

    // Address wrap on both sides.
    issue(9'd510, 24'hFF_FFFF, 3, RELU, 1'b1);
    expect_cycle("wrap", 1, 510, 0, 0, 1, 1);
    expect_cycle("wrap", 1, 511, 0, 0, 1, 1);
    expect_cycle("wrap", 1, 0, 0, 0, 1, 1);
    expect_cycle("wrap", 0, 0, 0, 0, 1, 0);
    expect_cycle("wrap", 0, 0, 1, 24'hFF_FFFF, 1, 0);
    expect_cycle("wrap", 0, 0, 1, 0, 1, 0);
    expect_cycle("wrap", 0, 0, 1, 1, 1, 0);
    expect_cycle("wrap", 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a long read burst.
    issue(9'd20, 24'd300, 10, SIGMOID, 1'b1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expect_cycle("rst_mid", 0, 0, 0, 0, 0, 0);
    chk("rst_mid_act", longint'(activation_function), longint'(NO_ACT));
    chk("rst_mid_rd_addr", longint'(acc_read_address), 0);
    chk("rst_mid_wr_addr", longint'(buffer_write_address), 0);
    repeat (15) step();
    basic_run("after_rst");

    // Randomized traffic with random stalls and occasional resets.
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int len;
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
      len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      issue(AW'($urandom), BW'($urandom), len, ($urandom_range(0, 1) == 1) ? RELU : SIGMOID,
            1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 15)) step();
    end
    rand_en = 1'b0;
    enable = 1'b1;
    repeat (30) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
